// File: rtl/tone_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tone_freq_meter
//  Description : Reciprocal frequency meter. Counts system-clock cycles
//                between two rising edges of an asynchronous square wave,
//                then divides CLK_HZ by that period with a 32-step
//                restoring divider to report the integer frequency in Hz.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_freq_meter #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_sig,
    output logic [15:0] o_freq,
    output logic        o_valid,
    output logic        o_timeout,
    output logic        o_busy
);

    localparam logic [31:0] DIVIDEND   = 32'(CLK_HZ);
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]  LAST_ITER  = 5'd31;
    localparam logic [31:0] FREQ_MAX   = 32'd65535;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        COUNT  = 2'd2,
        DIVIDE = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;

    // Input synchronizer and edge detector
    logic        sig_meta;
    logic        sig_sync;
    logic        sig_prev;
    logic        edge_pulse;

    // Period measurement and timeout
    logic [31:0] cnt;
    logic [31:0] timer;
    logic        timer_hit;

    // Restoring divider: quo starts as the dividend and fills with quotient bits
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [4:0]  iter;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] quo_next;
    logic [31:0] rem_next;

    // FSM decode strobes
    logic        load_cnt;
    logic        capture;
    logic        timeout_hit;
    logic        result_done;
    logic        timing;

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sig_meta <= 1'b0;
            sig_sync <= 1'b0;
            sig_prev <= 1'b0;
        end else begin
            sig_meta <= i_sig;
            sig_sync <= sig_meta;
            sig_prev <= sig_sync;
        end
    end

    assign edge_pulse = sig_sync & ~sig_prev;
    assign timer_hit  = (timer == TMO_LAST);
    assign timing     = (state == ARM) || (state == COUNT);

    // One restoring-division step: shift in the next dividend bit and try to subtract
    always_comb begin
        trial    = {rem, quo[31]} - {1'b0, divisor};
        q_bit    = ~trial[32];
        quo_next = {quo[30:0], q_bit};
        rem_next = q_bit ? trial[31:0] : {rem[30:0], quo[31]};
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode; disable overrides everything
    always_comb begin
        next_state  = state;
        load_cnt    = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        result_done = 1'b0;
        if (!i_en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    next_state = ARM;
                end
                ARM: begin
                    if (edge_pulse) begin
                        load_cnt   = 1'b1;
                        next_state = COUNT;
                    end else if (timer_hit) begin
                        timeout_hit = 1'b1;
                    end
                end
                COUNT: begin
                    if (edge_pulse) begin
                        capture    = 1'b1;
                        next_state = DIVIDE;
                    end else if (timer_hit) begin
                        timeout_hit = 1'b1;
                        next_state  = ARM;
                    end
                end
                DIVIDE: begin
                    if (iter == LAST_ITER) begin
                        result_done = 1'b1;
                        next_state  = ARM;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Timeout timer runs only while waiting for edges; any edge, expiry or other state clears it
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            timer <= 32'd0;
        end else if (i_en && timing && !edge_pulse && !timeout_hit) begin
            timer <= timer + 32'd1;
        end else begin
            timer <= 32'd0;
        end
    end

    // Period counter: starts at 1 on the opening edge so its value on the closing edge is the period
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt <= 32'd0;
        end else if (load_cnt) begin
            cnt <= 32'd1;
        end else if (i_en && (state == COUNT)) begin
            cnt <= cnt + 32'd1;
        end
    end

    // Divider datapath: load on capture, iterate once per DIVIDE cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            divisor <= 32'd0;
            quo     <= 32'd0;
            rem     <= 32'd0;
            iter    <= 5'd0;
        end else if (capture) begin
            divisor <= cnt;
            quo     <= DIVIDEND;
            rem     <= 32'd0;
            iter    <= 5'd0;
        end else if (i_en && (state == DIVIDE)) begin
            quo     <= quo_next;
            rem     <= rem_next;
            iter    <= iter + 5'd1;
        end
    end

    // Result registers: the final quotient bit is folded in combinationally so
    // o_valid lands 33 cycles after the closing edge pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_freq    <= 16'd0;
            o_timeout <= 1'b0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= result_done | timeout_hit;
            if (result_done) begin
                o_freq    <= (quo_next > FREQ_MAX) ? 16'hFFFF : quo_next[15:0];
                o_timeout <= 1'b0;
            end else if (timeout_hit) begin
                o_freq    <= 16'd0;
                o_timeout <= 1'b1;
            end
        end
    end

    assign o_busy = (state == DIVIDE);

endmodule
`default_nettype wire

// File: tb/tb_tone_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_freq_meter
//  Description : Directed self-checking bench for tone_freq_meter. Uses a
//                scaled clock (CLK_HZ = 200_000) so that test tones stay
//                within a short run: period 500 -> 400 Hz, 200 -> 1000 Hz,
//                454 -> 440 Hz, 4 -> 50000 Hz, 2 -> saturated 65535.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_freq_meter;

    localparam int unsigned CLK_HZ  = 200_000;
    localparam int unsigned TMO     = 1000;
    // Cycles from the first clock edge seeing a new i_sig level to o_valid:
    // 2 synchronizer cycles to the edge pulse plus 33 cycles of latency.
    localparam int          LAT     = 35;

    logic        clk;
    logic        reset;
    logic        en;
    logic        sig;
    logic [15:0] freq;
    logic        valid;
    logic        timeout;
    logic        busy;

    int          checks;
    int          passes;
    int          cyc;
    int          rise_cyc;
    int          sig_period;
    int          valid_cnt;
    int          vcyc;
    int          vcyc_prev;
    int          snap;
    bit          got;

    tone_freq_meter #(
        .CLK_HZ        (CLK_HZ),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_en     (en),
        .i_sig    (sig),
        .o_freq   (freq),
        .o_valid  (valid),
        .o_timeout(timeout),
        .o_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counts every o_valid pulse, sampled just after the active edge
    always @(posedge clk) begin
        #1;
        if (valid) valid_cnt++;
    end

    // Square-wave source; sig_period == 0 holds the line low
    initial begin
        sig = 1'b0;
        forever begin
            if (sig_period == 0) begin
                sig = 1'b0;
                @(negedge clk);
            end else begin
                sig      = 1'b1;
                rise_cyc = cyc;
                repeat (sig_period / 2) @(negedge clk);
                sig = 1'b0;
                repeat (sig_period - sig_period / 2) @(negedge clk);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid) begin
                ok   = 1'b1;
                vcyc = cyc;
                return;
            end
        end
    endtask

    task automatic wait_busy(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Quiesce, switch tone, and re-enable once the source is stable
    task automatic retune(input int period);
        en         = 1'b0;
        sig_period = period;
        repeat (1200) @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        cyc        = 0;
        rise_cyc   = 0;
        valid_cnt  = 0;
        vcyc       = 0;
        vcyc_prev  = 0;
        snap       = 0;
        got        = 1'b0;
        reset      = 1'b1;
        en         = 1'b0;
        sig_period = 4;

        // Reset with the input toggling, then stay disabled
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (1000) @(negedge clk);
        chk("idle_freq", 32'(freq), 0);
        chk("idle_timeout", 32'(timeout), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_valid_cnt", 32'(valid_cnt), 0);

        // 400 Hz, two consecutive results
        retune(500);
        for (int m = 0; m < 2; m++) begin
            wait_valid(3000, got);
            chk("m400_seen", 32'(got), 1);
            chk("m400_freq", 32'(freq), 400);
            chk("m400_timeout", 32'(timeout), 0);
            chk("m400_latency", 32'(vcyc - rise_cyc), LAT);
            chk("m400_busy_done", 32'(busy), 0);
            @(negedge clk);
            chk("m400_pulse_width", 32'(valid), 0);
        end

        // 1000 Hz loopback
        retune(200);
        for (int m = 0; m < 2; m++) begin
            wait_valid(2000, got);
            chk("m1000_seen", 32'(got), 1);
            chk("m1000_freq", 32'(freq), 1000);
            chk("m1000_latency", 32'(vcyc - rise_cyc), LAT);
        end

        // 440 Hz loopback: 200000/454 = 440.5 -> 440
        retune(454);
        wait_valid(3000, got);
        chk("m440_seen", 32'(got), 1);
        chk("m440_freq", 32'(freq), 440);

        // Largest unsaturated case here: 200000/4 = 50000
        retune(4);
        wait_valid(1000, got);
        chk("m50000_seen", 32'(got), 1);
        chk("m50000_freq", 32'(freq), 50000);

        // Minimum period: 200000/2 = 100000 saturates
        retune(2);
        wait_valid(1000, got);
        chk("msat_seen", 32'(got), 1);
        chk("msat_freq", 32'(freq), 65535);

        // Timeout: establish 400 Hz, then hold the line low
        retune(500);
        wait_valid(3000, got);
        chk("pre_tmo_freq", 32'(freq), 400);
        sig_period = 0;
        vcyc_prev  = vcyc;
        wait_valid(3000, got);
        chk("tmo_seen", 32'(got), 1);
        chk("tmo_freq", 32'(freq), 0);
        chk("tmo_flag", 32'(timeout), 1);
        chk("tmo_interval", 32'(vcyc - vcyc_prev), TMO);
        sig_period = 500;
        wait_valid(3000, got);
        chk("post_tmo_freq", 32'(freq), 400);
        chk("post_tmo_flag", 32'(timeout), 0);

        // Disable during divide iteration 10
        wait_busy(2000, got);
        chk("abort_en_busy_seen", 32'(got), 1);
        snap = valid_cnt;
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (60) @(negedge clk);
        chk("abort_en_no_valid", 32'(valid_cnt - snap), 0);
        chk("abort_en_freq_held", 32'(freq), 400);
        chk("abort_en_busy", 32'(busy), 0);
        chk("abort_en_timeout", 32'(timeout), 0);

        // Reset during divide iteration 10
        en = 1'b1;
        wait_busy(3000, got);
        chk("abort_rst_busy_seen", 32'(got), 1);
        snap = valid_cnt;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        chk("abort_rst_freq", 32'(freq), 0);
        chk("abort_rst_timeout", 32'(timeout), 0);
        chk("abort_rst_busy", 32'(busy), 0);
        chk("abort_rst_valid", 32'(valid), 0);
        repeat (40) @(negedge clk);
        chk("abort_rst_no_valid", 32'(valid_cnt - snap), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
